mmio_perf_io: RTL



---
 rtl/mmio_pkg.sv | 21 ++
 rtl/mmio_perf_io_sat_counter.sv | 38 +++
 rtl/mmio_perf_io.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO / performance-monitor block: I/O page
// offsets, CTRL register bit positions and the default halt marker.
`timescale 1ns/1ps
package mmio_pkg;

   // Word offsets within the I/O page (off = mem_addr[7:0])
   localparam logic [7:0] OFF_LED   = 8'h00;
   localparam logic [7:0] OFF_SW    = 8'h04;
   localparam logic [7:0] OFF_TOTAL = 8'h08;
   localparam logic [7:0] OFF_STALL = 8'h0C;
   localparam logic [7:0] OFF_FLUSH = 8'h10;
   localparam logic [7:0] OFF_CTRL  = 8'h14;

   // CTRL register bit positions
   localparam int unsigned CTRL_CLR = 0;
   localparam int unsigned CTRL_FRZ = 1;

   // LED value software writes to mark the end of a program
   localparam logic [7:0] HALT_PATTERN_DEFAULT = 8'h0F;

endpackage : mmio_pkg

// File: rtl/mmio_perf_io_sat_counter.sv
// sat_counter: CNT_W-wide up-counter that sticks at all-ones.
// clr has priority over everything; hold suppresses counting.
`timescale 1ns/1ps
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             clr_i,
   input  logic             hold_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise increment unless held or saturated
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !hold_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/mmio_perf_io.sv
// mmio_perf_io: I/O page decoder (LED, switches, CTRL) and the
// total/stall/flush performance counters with halt/freeze control.
// Optional switch debouncer is built when SW_DEBOUNCE_EN is defined.
`timescale 1ns/1ps
module mmio_perf_io
   import mmio_pkg::*;
#(
   parameter logic [15:0]  IO_BASE_HI      = 16'hFFFF,
   parameter logic [7:0]   HALT_PATTERN    = HALT_PATTERN_DEFAULT,
   parameter int unsigned  CNT_W           = 32,
   parameter int unsigned  DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   input  logic             mem_we,
   input  logic             mem_re,
   output logic             io_sel,
   output logic [31:0]      io_rdata,
   input  logic             stall_in,
   input  logic             flush_in,
   input  logic [7:0]       switches,
   output logic [7:0]       leds,
   output logic [CNT_W-1:0] total_cycles,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_cycles,
   output logic             halted
);

   logic [7:0] off_w;
   logic       led_we, ctrl_we, cnt_clr, cnt_hold;
   logic [7:0] leds_q, leds_d;
   logic       halted_q, halted_d;
   logic       freeze_q, freeze_d;
   logic [7:0] sw_meta_q, sw_sync_q, sw_val;
   logic       unused_bus;

   // Low address bits and the page-internal high byte do not take part in decode
   assign unused_bus = ^{mem_wdata[31:8], mem_addr[15:8], mem_addr[1:0]};

   assign io_sel  = (mem_addr[31:16] == IO_BASE_HI);
   assign off_w   = {mem_addr[7:2], 2'b00};
   assign led_we  = io_sel && mem_we && (off_w == OFF_LED);
   assign ctrl_we = io_sel && mem_we && (off_w == OFF_CTRL);

   assign cnt_clr  = ctrl_we && mem_wdata[CTRL_CLR];
   assign cnt_hold = halted_q || freeze_q;

   // Next-state for LED, halt and freeze registers
   always_comb begin
      leds_d   = leds_q;
      halted_d = halted_q;
      freeze_d = freeze_q;
      if (led_we) begin
         leds_d = mem_wdata[7:0];
         if (mem_wdata[7:0] == HALT_PATTERN) begin
            halted_d = 1'b1;
         end
      end
      if (ctrl_we) begin
         if (mem_wdata[CTRL_CLR]) begin
            halted_d = 1'b0;
         end
         if (mem_wdata[CTRL_FRZ]) begin
            freeze_d = 1'b1;
         end
      end
   end

   // Control/status registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         leds_q   <= '0;
         halted_q <= 1'b0;
         freeze_q <= 1'b0;
      end else begin
         leds_q   <= leds_d;
         halted_q <= halted_d;
         freeze_q <= freeze_d;
      end
   end

   assign leds   = leds_q;
   assign halted = halted_q;

   // Two-flop synchroniser for the asynchronous board switches
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= switches;
         sw_sync_q <= sw_meta_q;
      end
   end

`ifdef SW_DEBOUNCE_EN
   localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [7:0]       sw_cand_q, sw_deb_q, sw_deb_d;
   logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

   // Count consecutive identical samples; publish once the run is long enough
   always_comb begin
      deb_cnt_d = deb_cnt_q;
      sw_deb_d  = sw_deb_q;
      if (sw_sync_q != sw_cand_q) begin
         deb_cnt_d = DEB_W'(1);
      end else if (deb_cnt_q != DEB_W'(DEBOUNCE_CYCLES)) begin
         deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
      if (deb_cnt_d == DEB_W'(DEBOUNCE_CYCLES)) begin
         sw_deb_d = sw_sync_q;
      end
   end

   // Debouncer state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw_cand_q <= '0;
         sw_deb_q  <= '0;
         deb_cnt_q <= '0;
      end else begin
         sw_cand_q <= sw_sync_q;
         sw_deb_q  <= sw_deb_d;
         deb_cnt_q <= deb_cnt_d;
      end
   end

   assign sw_val = sw_deb_q;
`else
   logic unused_deb_cfg;

   // Debounce length only matters when the debouncer is built
   assign unused_deb_cfg = (DEBOUNCE_CYCLES == 0);
   assign sw_val         = sw_sync_q;
`endif

   // Performance counters
   sat_counter #(.CNT_W(CNT_W)) u_total (
      .clk(clk), .rst_n(rst_n), .inc_i(1'b1), .clr_i(cnt_clr),
      .hold_i(cnt_hold), .cnt_o(total_cycles)
   );

   sat_counter #(.CNT_W(CNT_W)) u_stall (
      .clk(clk), .rst_n(rst_n), .inc_i(stall_in), .clr_i(cnt_clr),
      .hold_i(cnt_hold), .cnt_o(stall_cycles)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush (
      .clk(clk), .rst_n(rst_n), .inc_i(flush_in), .clr_i(cnt_clr),
      .hold_i(cnt_hold), .cnt_o(flush_cycles)
   );

   // Zero-latency read mux over the current register state
   always_comb begin
      io_rdata = '0;
      if (io_sel && mem_re) begin
         case (off_w)
            OFF_LED:   io_rdata = {24'b0, leds_q};
            OFF_SW:    io_rdata = {24'b0, sw_val};
            OFF_TOTAL: io_rdata = 32'(total_cycles);
            OFF_STALL: io_rdata = 32'(stall_cycles);
            OFF_FLUSH: io_rdata = 32'(flush_cycles);
            OFF_CTRL:  io_rdata = {30'b0, freeze_q, halted_q};
            default:   io_rdata = '0;
         endcase
      end
   end

endmodule : mmio_perf_io
